// File: rtl/dial_entry.sv
// rtl/dial_entry.sv - keypad dial-number entry: strobe synchronizer, action decode, entry FSM
// Optional feature macro: DIAL_BACKSPACE_EN (clear with a non-empty buffer removes only the newest digit)
module dial_entry (
    input  logic        CLK,
    input  logic        RST,
    input  logic        startSet,
    input  logic [4:0]  num,
    input  logic        start,
    input  logic        clear,
    input  logic        enter,
    output logic [31:0] digits,
    output logic [3:0]  count,
    output logic        active,
    output logic        dial_valid,
    output logic [31:0] dial_number,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        A_NONE  = 3'd0,
        A_START = 3'd1,
        A_CLEAR = 3'd2,
        A_ENTER = 3'd3,
        A_DIGIT = 3'd4
    } act_t;

    localparam logic [31:0] EMPTY_BUF = 32'hFFFF_FFFF;
    localparam logic [3:0]  MAX_COUNT = 4'd8;

    logic   sync1, sync2, sync3;
    logic   key_event;
    act_t   act_dec, act_q;
    logic [3:0] digit_q;

    state_t state_q, state_d;
    logic [31:0] digits_d, dial_number_d;
    logic [3:0]  count_d;
    logic        dial_valid_d, overflow_d;

    // Bring the asynchronous key strobe into CLK domain and keep one history flop for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= startSet;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // A held strobe yields exactly one event: only the synchronized rising edge counts
    assign key_event = sync2 & ~sync3;

    // Resolve one action per event: start beats clear beats enter beats a valid digit
    always_comb begin
        act_dec = A_NONE;
        if (start) begin
            act_dec = A_START;
        end else if (clear) begin
            act_dec = A_CLEAR;
        end else if (enter) begin
            act_dec = A_ENTER;
        end else if (num <= 5'd9) begin
            act_dec = A_DIGIT;
        end
    end

    // Capture the decoded action on the event cycle; reset drops any event still in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            act_q   <= A_NONE;
            digit_q <= 4'd0;
        end else begin
            act_q   <= key_event ? act_dec : A_NONE;
            digit_q <= num[3:0];
        end
    end

    // Next-state and next-output logic of the entry state machine
    always_comb begin
        state_d       = state_q;
        digits_d      = digits;
        count_d       = count;
        dial_number_d = dial_number;
        dial_valid_d  = 1'b0;
        overflow_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (act_q == A_START) begin
                    state_d  = S_ENTRY;
                    digits_d = EMPTY_BUF;
                    count_d  = 4'd0;
                end
            end

            S_ENTRY: begin
                case (act_q)
                    A_START: begin
                        digits_d = EMPTY_BUF;
                        count_d  = 4'd0;
                    end
                    A_CLEAR: begin
                        if (count == 4'd0) begin
                            state_d  = S_IDLE;
                            digits_d = EMPTY_BUF;
                        end else begin
`ifdef DIAL_BACKSPACE_EN
                            digits_d = {4'hF, digits[31:4]};
                            count_d  = count - 4'd1;
`else
                            digits_d = EMPTY_BUF;
                            count_d  = 4'd0;
`endif
                        end
                    end
                    A_ENTER: begin
                        if (count != 4'd0) begin
                            dial_number_d = digits;
                            dial_valid_d  = 1'b1;
                            state_d       = S_DONE;
                        end
                    end
                    A_DIGIT: begin
                        if (count == MAX_COUNT) begin
                            overflow_d = 1'b1;
                        end else begin
                            digits_d = {digits[27:0], digit_q};
                            count_d  = count + 4'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            S_DONE: begin
                if (act_q == A_START) begin
                    state_d  = S_ENTRY;
                    digits_d = EMPTY_BUF;
                    count_d  = 4'd0;
                end else if (act_q == A_CLEAR) begin
                    state_d  = S_IDLE;
                    digits_d = EMPTY_BUF;
                    count_d  = 4'd0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                digits_d = EMPTY_BUF;
                count_d  = 4'd0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            digits      <= EMPTY_BUF;
            count       <= 4'd0;
            dial_number <= EMPTY_BUF;
            dial_valid  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits      <= digits_d;
            count       <= count_d;
            dial_number <= dial_number_d;
            dial_valid  <= dial_valid_d;
            overflow    <= overflow_d;
        end
    end

    assign active = (state_q == S_ENTRY);

endmodule

// File: tb/tb_dial_entry.sv
// tb/tb_dial_entry.sv - directed bench for dial_entry with a commit scoreboard
module tb_dial_entry;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        startSet = 1'b0;
    logic [4:0]  num = 5'd20;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic [31:0] digits;
    logic [3:0]  count;
    logic        active;
    logic        dial_valid;
    logic [31:0] dial_number;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;
    int dv_seen    = 0;
    int ov_seen    = 0;
    int ov_expect  = 0;
    logic prev_dv  = 1'b0;
    logic prev_ov  = 1'b0;
    logic [31:0] commit_q[$];

    dial_entry dut (
        .CLK         (CLK),
        .RST         (RST),
        .startSet    (startSet),
        .num         (num),
        .start       (start),
        .clear       (clear),
        .enter       (enter),
        .digits      (digits),
        .count       (count),
        .active      (active),
        .dial_valid  (dial_valid),
        .dial_number (dial_number),
        .overflow    (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every commit pulse pops the number expected at enter time
    always @(negedge CLK) begin
        if (dial_valid === 1'b1) begin
            dv_seen++;
            if (commit_q.size() == 0) begin
                check("unexpected_dial_valid", 32'd1, 32'd0);
            end else begin
                check("dial_number_on_commit", dial_number, commit_q.pop_front());
            end
        end
        if (overflow === 1'b1) ov_seen++;
        if ((prev_dv | prev_ov) && (dial_valid | overflow))
            check("pulse_back_to_back", 32'd1, 32'd0);
        prev_dv = dial_valid;
        prev_ov = overflow;
    end

    task automatic press(input logic s, input logic c, input logic e, input logic [4:0] n, input int hold);
        @(negedge CLK);
        start = s; clear = c; enter = e; num = n;
        startSet = 1'b1;
        repeat (3) @(posedge CLK);
        repeat (hold) @(negedge CLK);
        @(negedge CLK);
        startSet = 1'b0; start = 1'b0; clear = 1'b0; enter = 1'b0; num = 5'd20;
        @(negedge CLK);
        repeat (2) @(negedge CLK);
    endtask

    task automatic digit(input logic [4:0] n);
        press(1'b0, 1'b0, 1'b0, n, 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_digits", digits, 32'hFFFFFFFF);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_dial_number", dial_number, 32'hFFFFFFFF);
        check("rst_pulses", {30'd0, dial_valid, overflow}, 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        digit(5'd4);
        check("idle_ignores_digit", {27'd0, active, count}, 32'd0);

        press(1'b1, 1'b0, 1'b0, 5'd20, 0);
        check("start_active", {31'd0, active}, 32'd1);
        check("start_digits", digits, 32'hFFFFFFFF);

        digit(5'd1); digit(5'd3); digit(5'd8);
        check("three_digits", digits, 32'hFFFFF138);
        check("three_count", {28'd0, count}, 32'd3);
        digit(5'd25);
        check("invalid_num_ignored", {28'd0, count}, 32'd3);
        commit_q.push_back(32'hFFFFF138);
        press(1'b0, 1'b0, 1'b1, 5'd20, 0);
        check("done_inactive", {31'd0, active}, 32'd0);
        check("done_count", {28'd0, count}, 32'd3);
        check("dial_number_held", dial_number, 32'hFFFFF138);

        digit(5'd7);
        check("done_ignores_digit", digits, 32'hFFFFF138);

        press(1'b1, 1'b0, 1'b0, 5'd20, 0);
        check("done_start", {27'd0, active, count}, 32'h10);
        for (int i = 0; i < 8; i++) digit(5'd5);
        check("eight_fives", digits, 32'h55555555);
        check("eight_count", {28'd0, count}, 32'd8);
        ov_expect++;
        digit(5'd5);
        check("overflow_buffer_hold", digits, 32'h55555555);
        check("overflow_pulses", ov_seen, ov_expect);
        commit_q.push_back(32'h55555555);
        press(1'b0, 1'b0, 1'b1, 5'd20, 0);
        check("commit_fives", dial_number, 32'h55555555);

        press(1'b0, 1'b1, 1'b0, 5'd20, 0);
        check("done_clear_idle", {27'd0, active, count}, 32'd0);
        check("done_clear_digits", digits, 32'hFFFFFFFF);

        press(1'b1, 1'b0, 1'b0, 5'd20, 0);
        digit(5'd1); digit(5'd2);
        press(1'b0, 1'b1, 1'b0, 5'd20, 0);
`ifdef DIAL_BACKSPACE_EN
        check("backspace_digits", digits, 32'hFFFFFFF1);
        check("backspace_count", {28'd0, count}, 32'd1);
        press(1'b0, 1'b1, 1'b0, 5'd20, 0);
        check("backspace_empty", {27'd0, active, count}, 32'h10);
`else
        check("clear_digits", digits, 32'hFFFFFFFF);
        check("clear_count", {28'd0, count}, 32'd0);
`endif
        press(1'b0, 1'b1, 1'b0, 5'd20, 0);
        check("clear_empty_idle", {31'd0, active}, 32'd0);

        press(1'b1, 1'b0, 1'b0, 5'd20, 0);
        digit(5'd7); digit(5'd7);
        press(1'b1, 1'b1, 1'b0, 5'd4, 0);
        check("start_beats_clear", {27'd0, active, count}, 32'h10);
        check("start_beats_digit", digits, 32'hFFFFFFFF);
        press(1'b0, 1'b0, 1'b1, 5'd20, 0);
        check("enter_empty_ignored", {31'd0, active}, 32'd1);

        press(1'b0, 1'b0, 1'b0, 5'd6, 100);
        check("held_strobe_count", {28'd0, count}, 32'd1);
        check("held_strobe_digits", digits, 32'hFFFFFFF6);

        for (int i = 0; i < 4; i++) digit(5'd2);
        check("mid_entry_count", {28'd0, count}, 32'd5);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async_rst_digits", digits, 32'hFFFFFFFF);
        check("async_rst_state", {27'd0, active, count}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        digit(5'd3);
        check("post_rst_digit_ignored", {27'd0, active, count}, 32'd0);

        @(negedge CLK);
        start = 1'b1; startSet = 1'b1;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("inflight_discarded", {31'd0, active}, 32'd0);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        check("held_through_rst_one_event", {27'd0, active, count}, 32'h10);
        startSet = 1'b0; start = 1'b0;
        repeat (3) @(negedge CLK);
        digit(5'd9);
        check("after_restart_digit", digits, 32'hFFFFFFF9);

        repeat (3) @(negedge CLK);
        check("commit_pulses_total", dv_seen, 2);
        check("overflow_pulses_total", ov_seen, ov_expect);
        check("scoreboard_drained", commit_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dial_entry.md
DIAL_ENTRY -- requirements
Module: dial_entry

Interface
REQ-001 SHALL have port: CLK  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: RST  input  1  reset; asynchronous and active-high.
REQ-003 SHALL have port: startSet  input  1  key-event strobe from the keypad scanner; one rising edge per debounced press.
REQ-004 SHALL have port: num  input  5  digit code; 0-9 valid, 20 = no digit, other values treated as no digit.
REQ-005 SHALL have port: start  input  1  start key level, qualified by startSet.
REQ-006 SHALL have port: clear  input  1  clear key level, qualified by startSet.
REQ-007 SHALL have port: enter  input  1  enter key level, qualified by startSet.
REQ-008 SHALL have port: digits  output  32  entry buffer, 8 BCD nibbles, newest digit in [3:0], unused nibbles 4'hF.
REQ-009 SHALL have port: count  output  4  number of digits in buffer, 0-8.
REQ-010 SHALL have port: active  output  1  high while in ENTRY.
REQ-011 SHALL have port: dial_valid  output  1  one-cycle pulse when a number is committed.
REQ-012 SHALL have port: dial_number  output  32  last committed buffer, held until next commit.
REQ-013 SHALL have port: overflow  output  1  one-cycle pulse when a digit arrives with count==8.

Function
REQ-014 SHALL pass startSet through a 2-flop synchronizer plus one history flop; key event = sync2 & ~sync3.
REQ-015 SHALL sample num/start/clear/enter on the key-event cycle; registered outputs update at edge k+3, where k is the first edge sampling startSet high.
REQ-016 SHALL generate exactly one key event per startSet rising edge; a held startSet produces no further events.
REQ-017 SHALL decode one action per event with priority start > clear > enter > digit; an event with no valid action is ignored.
REQ-018 SHALL implement states IDLE, ENTRY, DONE; active=1 only in ENTRY.
REQ-019 IDLE: on start, SHALL go to ENTRY with digits=32'hFFFFFFFF and count=0; SHALL ignore all other actions.
REQ-020 ENTRY digit, count<8: SHALL set digits={digits[27:0],num[3:0]} and count=count+1.
REQ-021 ENTRY digit, count==8: SHALL leave buffer unchanged and pulse overflow for one cycle.
REQ-022 ENTRY start: SHALL clear the buffer to all-F, set count=0, and stay in ENTRY.
REQ-023 ENTRY clear with count==0: SHALL go to IDLE.
REQ-024 ENTRY clear with count>0: behaviour SHALL be as defined in Configuration.
REQ-025 ENTRY enter with count>0: SHALL set dial_number=digits, pulse dial_valid for one cycle, and go to DONE.
REQ-026 ENTRY enter with count==0: SHALL be ignored.
REQ-027 DONE: start SHALL go to ENTRY with the buffer cleared.
REQ-028 DONE: clear SHALL go to IDLE with the buffer cleared.
REQ-029 DONE: digit and enter SHALL be ignored; digits and count SHALL hold.
REQ-030 dial_valid and overflow SHALL never be high in consecutive cycles.

Reset
REQ-031 RST high SHALL asynchronously force: state=IDLE, digits=32'hFFFFFFFF, count=0, active=0, dial_valid=0, overflow=0, dial_number=32'hFFFFFFFF, all synchronizer flops=0.
REQ-032 Assertion of RST during an in-flight event SHALL discard that event.
REQ-033 After RST deasserts, a startSet already high SHALL produce one event.

Configuration
REQ-034 Macro DIAL_BACKSPACE_EN defined: ENTRY clear with count>0 SHALL set digits={4'hF,digits[31:4]} and count=count-1, staying in ENTRY.
REQ-035 Macro DIAL_BACKSPACE_EN undefined: ENTRY clear with count>0 SHALL clear the buffer to all-F, set count=0, and stay in ENTRY.

Verification
REQ-036 Reset, then start, digits 1,3,8, enter -> dial_number=32'hFFFFF138, count=3, one dial_valid pulse, state DONE.
REQ-037 start, 9 digits of 5, enter -> one overflow pulse on the 9th digit; dial_number=32'h55555555.
REQ-038 start, digits 1,2, clear -> with macro: digits=32'hFFFFFFF1, count=1; without macro: digits=32'hFFFFFFFF, count=0; second clear (count==0) -> IDLE.
REQ-039 Event with start=1 and clear=1, num=4 in ENTRY -> start wins; count=0, no digit stored.
REQ-040 startSet held high 100 cycles after one digit -> count increments by exactly 1.
REQ-041 RST pulsed mid-entry (count=5) -> all outputs at reset values same cycle; later digit events ignored until start.
